// File: rtl/uart_tx_scheduler_pkg.sv
// ---- uart_tx_scheduler_pkg : shared types/constants for the UART TX scheduler ----
// ---- Rev 1.0 ----
`default_nettype none

package uart_tx_scheduler_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_GAP    = 2'd3
  } state_t;

  localparam int BAUD       = 9600;
  localparam int FRAME_BITS = 11;  // start + 8 data + parity + stop

  function automatic int gw_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// ---- uart_tx_scheduler_rr_arbiter : round-robin winner search with registered pointer ----
// ---- Rev 1.0 ----
`default_nettype none

module uart_tx_scheduler_rr_arbiter
  import uart_tx_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int GW      = gw_of(NUM_REQ)
) (
  input  logic               clk_tx,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_advance,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [GW-1:0]      o_idx,
  output logic               o_found
);

  logic [GW-1:0] r_ptr;

  // Search starts one past the last winner so a held request cannot starve others.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!o_found && i_req[(int'(r_ptr) + k) % NUM_REQ]) begin
        o_found = 1'b1;
        o_idx   = GW'((int'(r_ptr) + k) % NUM_REQ);
        o_grant[(int'(r_ptr) + k) % NUM_REQ] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_tx or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= GW'(NUM_REQ - 1);
    end else if (i_advance && o_found) begin
      r_ptr <= o_idx;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
// ---- uart_tx_scheduler : shares one UART TX engine among NUM_REQ byte producers ----
// ---- Rev 1.0 ----
`default_nettype none

module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter  int NUM_REQ       = 4,
  parameter  int GAP_CYCLES    = 16,
  parameter  int START_TIMEOUT = 8,
  localparam int GW            = gw_of(NUM_REQ)
) (
  input  logic                 clk_tx,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] data_flat,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 tx_en,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [GW-1:0]        grant_id,
  output logic                 err_timeout,
  output logic                 idle
);

  localparam int TW = $clog2(START_TIMEOUT);
  localparam int CW = $clog2(GAP_CYCLES) + 1;

  state_t              r_state;
  logic [TW-1:0]       r_tmo;
  logic [CW-1:0]       r_gap;
  logic [NUM_REQ-1:0]  w_grant;
  logic [GW-1:0]       w_idx;
  logic                w_found;
  logic                w_launch;

  assign w_launch = (r_state == S_IDLE) && w_found && !tx_busy;
  assign idle     = (r_state == S_IDLE) && !tx_busy;

  uart_tx_scheduler_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .GW      (GW)
  ) u_arb (
    .clk_tx    (clk_tx),
    .rst_n     (rst_n),
    .i_req     (req),
    .i_advance (w_launch),
    .o_grant   (w_grant),
    .o_idx     (w_idx),
    .o_found   (w_found)
  );

  always_ff @(posedge clk_tx or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_tmo       <= '0;
      r_gap       <= '0;
      ack         <= '0;
      tx_en       <= 1'b0;
      tx_data     <= 8'h00;
      grant_id    <= '0;
      err_timeout <= 1'b0;
    end else begin
      ack         <= '0;
      err_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            tx_data  <= data_flat[{w_idx, 3'b000} +: 8];
            ack      <= w_grant;
            grant_id <= w_idx;
            tx_en    <= 1'b1;
            r_tmo    <= '0;
            r_state  <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          if (tx_busy) begin
            tx_en   <= 1'b0;
            r_state <= S_WAIT;
          end else if (r_tmo == TW'(START_TIMEOUT - 1)) begin
            // Byte was already acked, so a dead engine loses it without retry.
            tx_en       <= 1'b0;
            err_timeout <= 1'b1;
            r_gap       <= '0;
            r_state     <= S_GAP;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        S_WAIT: begin
          if (!tx_busy) begin
            r_gap   <= '0;
            r_state <= S_GAP;
          end
        end
        S_GAP: begin
          if (r_gap == CW'(GAP_CYCLES - 1)) begin
            r_state <= S_IDLE;
          end else begin
            r_gap <= r_gap + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
// ---- tb_uart_tx_scheduler : scoreboard bench for uart_tx_scheduler ----
// ---- Rev 1.0 ----
`default_nettype none

module tb_uart_tx_scheduler;

  localparam int NR    = 4;
  localparam int GAP   = 16;
  localparam int STO   = 8;
  localparam int FRAME = 20;

  typedef struct {
    int         id;
    logic [7:0] d;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req;
  logic [8*NR-1:0] data_flat;
  logic [NR-1:0]   ack;
  logic            tx_en;
  logic [7:0]      tx_data;
  logic            tx_busy;
  logic [1:0]      grant_id;
  logic            err_timeout;
  logic            idle;

  logic eng_busy, eng_dead, hold_busy;
  int   ecnt;
  int   cyc = 0;
  int   vec = 0;
  int   errs = 0;
  exp_t q[$];
  exp_t mon_e;

  assign tx_busy = eng_busy | hold_busy;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  uart_tx_scheduler #(
    .NUM_REQ       (NR),
    .GAP_CYCLES    (GAP),
    .START_TIMEOUT (STO)
  ) dut (
    .clk_tx      (clk),
    .rst_n       (rst_n),
    .req         (req),
    .data_flat   (data_flat),
    .ack         (ack),
    .tx_en       (tx_en),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .grant_id    (grant_id),
    .err_timeout (err_timeout),
    .idle        (idle)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic push(input int id, input logic [7:0] d);
    exp_t e;
    e.id = id;
    e.d  = d;
    q.push_back(e);
  endtask

  task automatic wait_acks(input int n, input bit drop, input string nm);
    int got = 0;
    int t   = 0;
    while (got < n && t < 800) begin
      @(posedge clk); #1;
      t++;
      if (ack != '0) begin
        got++;
        if (drop) req = req & ~ack;
      end
    end
    if (got < n) begin
      vec++; errs++;
      $display("FAIL %s_acks: got %0d acks required %0d", nm, got, n);
    end
  endtask

  task automatic wait_busy(input logic val, input string nm);
    int t = 0;
    while (tx_busy !== val && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    if (tx_busy !== val) begin
      vec++; errs++;
      $display("FAIL %s_busy: got %b required %b", nm, tx_busy, val);
    end
  endtask

  task automatic wait_idle(input string nm);
    int t = 0;
    while (idle !== 1'b1 && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    if (idle !== 1'b1) begin
      vec++; errs++;
      $display("FAIL %s_idle: got %b required 1", nm, idle);
    end
  endtask

  // Engine model: busy 3 cycles after tx_en, then FRAME cycles of framing.
  initial begin
    eng_busy = 1'b0;
    ecnt     = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        eng_busy = 1'b0;
        ecnt     = 0;
      end else if (!eng_busy) begin
        if (tx_en && !eng_dead) begin
          ecnt++;
          if (ecnt == 3) begin
            eng_busy = 1'b1;
            ecnt     = 0;
          end
        end else begin
          ecnt = 0;
        end
      end else begin
        ecnt++;
        if (ecnt == FRAME) begin
          eng_busy = 1'b0;
          ecnt     = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && ack != '0) begin
      chk("ack_onehot", 32'($countones(ack)), 32'd1);
      if (q.size() == 0) begin
        vec++; errs++;
        $display("FAIL unexpected_ack: got %b required none", ack);
      end else begin
        mon_e = q.pop_front();
        chk("ack_id", 32'(ack), 32'(1 << mon_e.id));
        chk("grant_id", 32'(grant_id), 32'(mon_e.id));
        chk("tx_data", 32'(tx_data), 32'(mon_e.d));
        chk("tx_en_at_ack", 32'(tx_en), 32'd1);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, n2, t0, cnt;
    rst_n = 1'b0; req = '0; data_flat = '0;
    eng_dead = 1'b0; hold_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_en", 32'(tx_en), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_err", 32'(err_timeout), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: single requester, latency, hold, inter-frame gap
    data_flat[7:0] = 8'hA5; push(0, 8'hA5); req = 4'b0001;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (ack[0] !== 1'b1 && n < 20);
    req[0] = 1'b0;
    chk("t1_latency", 32'(n), 32'd1);
    wait_busy(1'b1, "t1");
    chk("t1_txen_drop", 32'(tx_en), 32'd0);
    chk("t1_data_hold", 32'(tx_data), 32'hA5);
    wait_busy(1'b0, "t1");
    t0 = cyc;
    data_flat[7:0] = 8'h5A; push(0, 8'h5A); req = 4'b0001;
    n = 0;
    while (tx_en !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    req[0] = 1'b0;
    chk("t1_gap", 32'(cyc - t0), 32'(GAP + 1));
    wait_idle("t1");

    // 2: all four held after a fresh reset -> 0,1,2,3,0
    rst_n = 1'b0; @(posedge clk); #1; rst_n = 1'b1;
    data_flat = 32'h44332211;
    push(0, 8'h11); push(1, 8'h22); push(2, 8'h33); push(3, 8'h44); push(0, 8'h11);
    req = 4'b1111;
    wait_acks(5, 1'b0, "t2");
    req = '0;
    wait_idle("t2");

    // 3: pointer at 2, req 0011 wraps to 0 then 1
    data_flat[23:16] = 8'h77; push(2, 8'h77); req = 4'b0100;
    wait_acks(1, 1'b1, "t3a");
    wait_idle("t3a");
    data_flat[7:0] = 8'hC3; data_flat[15:8] = 8'h3C;
    push(0, 8'hC3); push(1, 8'h3C); req = 4'b0011;
    wait_acks(2, 1'b1, "t3b");
    wait_idle("t3b");

    // 4: dead engine -> timeout
    eng_dead = 1'b1;
    data_flat[7:0] = 8'h99; push(0, 8'h99); req = 4'b0001;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (ack[0] !== 1'b1 && n < 20);
    req[0] = 1'b0;
    n = 0;
    while (tx_en === 1'b1 && n < 50) begin n++; @(posedge clk); #1; end
    chk("t4_txen_len", 32'(n), 32'(STO));
    chk("t4_err_at_drop", 32'(err_timeout), 32'd1);
    n2 = 0; cnt = 0;
    while (idle !== 1'b1 && n2 < 100) begin
      @(posedge clk); #1; n2++;
      if (err_timeout) cnt++;
    end
    chk("t4_gap_len", 32'(n2), 32'(GAP));
    chk("t4_err_single", 32'(cnt), 32'd0);
    eng_dead = 1'b0;

    // 5: reset during WAIT, then requester 0 first
    data_flat[23:16] = 8'h5C; push(2, 8'h5C); req = 4'b0100;
    wait_acks(1, 1'b0, "t5a");
    wait_busy(1'b1, "t5");
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b0; #1;
    chk("t5_rst_tx_en", 32'(tx_en), 32'd0);
    chk("t5_rst_tx_data", 32'(tx_data), 32'd0);
    chk("t5_rst_grant_id", 32'(grant_id), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    data_flat[7:0] = 8'hE1; req = 4'b0101;
    push(0, 8'hE1); push(2, 8'h5C);
    rst_n = 1'b1;
    wait_acks(2, 1'b1, "t5b");
    wait_idle("t5b");

    // 6: busy engine in IDLE blocks launch
    hold_busy = 1'b1;
    @(posedge clk); #1;
    data_flat[7:0] = 8'h0F; req = 4'b0001;
    cnt = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ack != '0 || tx_en) cnt++;
    end
    chk("t6_blocked", 32'(cnt), 32'd0);
    chk("t6_idle_low", 32'(idle), 32'd0);
    push(0, 8'h0F);
    hold_busy = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (ack[0] !== 1'b1 && n < 20);
    req[0] = 1'b0;
    chk("t6_latency", 32'(n), 32'd1);
    wait_idle("t6");

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

`default_nettype wire
